// File: rtl/fifo_tx_serializer.sv
// Drains a flagless FIFO and sends each byte as an async serial frame (start, LSB-first data, stop).
// Define SER_PARITY_EN to insert an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module fifo_tx_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              SER_reset_n,
  input  logic [DATA_W-1:0] fifo_data_in,
  input  logic              fifo_push,
  output logic              fifo_pop,
  input  logic              fifo_flush,
  input  logic              enable,
  input  logic [DIV_W-1:0]  baud_div,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  level,
  output logic              overflow
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              pop_q, pop_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic bit_end;
  logic can_start;
  logic load;

  assign fifo_pop = pop_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign level    = level_q;
  assign overflow = ovf_q;

  // Shadow occupancy: tracks the FIFO from its push strobe and our own registered pop.
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    if (fifo_flush) begin
      level_d = '0;
      ovf_d   = 1'b0;
    end else if (fifo_push && !pop_q) begin
      if (level_q == CNT_W'(DEPTH)) ovf_d = 1'b1;
      else                          level_d = level_q + CNT_W'(1);
    end else if (!fifo_push && pop_q && (level_q != '0)) begin
      level_d = level_q - CNT_W'(1);
    end
  end

  assign bit_end   = (baud_q == div_q);
  assign can_start = enable && (level_q != '0) && !fifo_flush;
  assign load      = can_start && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop_d   = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + DIV_W'(1);

    unique case (state_q)
      S_IDLE: ;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef SER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Loading from IDLE or the last STOP cycle shares one path so back-to-back frames have no gap.
    if (load) begin
      state_d = S_START;
      sh_d    = fifo_data_in;
      div_d   = baud_div;
      baud_d  = '0;
      bit_d   = '0;
      pop_d   = 1'b1;
`ifdef SER_PARITY_EN
      par_d   = ^fifo_data_in;
`endif
    end
  end

  // Line level follows the registered state, so tx falls one clock after the pop strobe.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_q[0];
`ifdef SER_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge SER_reset_n) begin
    if (!SER_reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      pop_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pop_q   <= pop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Downstream consumer of the 16x8 push/pop FIFO: drains bytes from the FIFO read port and transmits them as asynchronous serial frames (start, 8 data LSB-first, stop).
- The FIFO exposes no flags, so this block keeps a shadow occupancy count by snooping the FIFO push strobe and its own pop strobe.
- It drives the FIFO pop input directly and sits between the FIFO and the pad/line driver.

Parameters:
- DATA_W, 8, data word width; must equal the FIFO data width.
- DEPTH, 16, FIFO depth; the shadow count saturates here.
- CNT_W, 5, shadow-count width; must hold 0..DEPTH inclusive.
- DIV_W, 16, baud divisor width.

Ports:
- clk  input  1  system clock, shared with FIFO
- SER_reset_n  input  1  asynchronous active-low reset
- fifo_data_in  input  DATA_W  FIFO data_out (head entry, combinational)
- fifo_push  input  1  snoop of the FIFO push strobe
- fifo_pop  output  1  pop strobe to the FIFO, single-cycle
- fifo_flush  input  1  sync active-high; pulse whenever the FIFO is reset or cleared
- enable  input  1  permits starting new frames
- baud_div  input  DIV_W  clocks per bit minus 1
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress
- level  output  CNT_W  shadow FIFO occupancy
- overflow  output  1  sticky: push seen while level==DEPTH without pop

Behaviour:
- Reset (async, SER_reset_n low): tx=1, fifo_pop=0, busy=0, level=0, overflow=0, FSM=IDLE, bit and baud counters=0. All outputs are registered.
- Occupancy: level_next = level + fifo_push - fifo_pop.
  - push and pop in the same cycle: level unchanged.
  - push at level==DEPTH with no pop: level holds DEPTH and overflow is set (sticky until reset or flush).
  - Pop is never issued at level==0, so level cannot underflow.
- fifo_flush: next cycle level=0 and overflow=0. fifo_pop is forced 0 in the flush cycle. A frame already in progress completes from its shift register copy.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if enable && level!=0 && !fifo_flush:
  - capture fifo_data_in into the shift register;
  - latch baud_div;
  - assert fifo_pop for exactly this cycle;
  - next state START.
  - A push in the same cycle with level==0 does not start a frame (data not yet written).
- Bit timing: every bit lasts latched_div+1 clocks (baud_div=0 gives 1 clk/bit). baud_div changes mid-frame are ignored.
- START: tx=0 from the cycle after pop (latency 1 clk pop->tx fall).
- DATA: 8 bits, LSB first, bit counter 0..DATA_W-1, shift right per bit.
- STOP: tx=1 for one bit time. In the final STOP cycle, if enable && level!=0 && !fifo_flush, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- busy=1 in START/DATA/STOP; 0 in IDLE.
- enable deasserted mid-frame: the frame finishes; no new frame starts.
- Frame length (no parity) = 10*(baud_div+1) clocks.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and transmits one even-parity bit (XOR of the 8 data bits) for one bit time. Frame length = 11*(baud_div+1).
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset with tx idle: hold SER_reset_n low mid-frame -> tx=1, busy=0, level=0, fifo_pop=0 immediately (asynchronously).
- Single byte: baud_div=3, push 0xA5, enable=1 -> one fifo_pop pulse, level 1->0, tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, stop high 4 clks, busy low after 40 clks.
- Back-to-back: push 0x01, 0x80, 0xFF with baud_div=0 -> three frames of 10 clks with no idle gap, exactly 3 pops, level ends at 0.
- Simultaneous push+pop: at level=1 push in the same cycle IDLE pops -> level stays 1, and the second frame follows immediately after the first STOP.
- Overflow and flush: enable=0, 17 pushes -> level=16, overflow=1. Pulse fifo_flush -> level=0, overflow=0, no pop issued.
- Parity (SER_PARITY_EN defined): send 0x07 with baud_div=1 -> parity bit 1, frame 22 clks. Without the macro -> 20 clks.
